mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Each grant runs IDLE -> BUSY -> DONE, with a timeout abort while waiting in BUSY.
module mem_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          req_err,
    output logic [WIDTH-1:0]              req_rdata,
    output logic                          mem_valid,
    output logic                          mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic [WIDTH-1:0]              mem_rdata,
    input  logic                          mem_ready,
    output logic [1:0]                    grant_id,
    output logic                          busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [CW-1:0]           cnt;
    logic [1:0]              last_grant;
    logic [1:0]              pick;
    logic                    any;
    logic [2:0]              idx;
    logic [3:0]              vpad;
    logic [3:0]              gnt_oh;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [WIDTH-1:0]        sel_wdata;
    logic                    tmo;

    assign vpad   = 4'(req_valid);
    assign gnt_oh = 4'b0001 << grant_id;
    assign tmo    = (cnt == CW'(TIMEOUT - 1));
    assign busy   = (state != IDLE);

    // Round-robin pick: scan upward from the requester after last_grant, with wrap.
    always_comb begin
        any       = 1'b0;
        pick      = last_grant;
        idx       = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant} + 3'(k);
            if (idx >= 3'(NUM_REQ))
                idx = idx - 3'(NUM_REQ);
            if (!any && vpad[idx[1:0]]) begin
                any  = 1'b1;
                pick = idx[1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 2'(i)) begin
                sel_wr    = req_wr_rd[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; memory handshake only matters in BUSY.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (any) state_nx = BUSY;
            BUSY: if (mem_ready || tmo) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs: latch the grant, count the wait, pulse completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_wr_rd  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_ready  <= '0;
            req_err    <= 1'b0;
            req_rdata  <= '0;
            cnt        <= '0;
            grant_id   <= '0;
            last_grant <= 2'(NUM_REQ - 1);
        end else begin
            req_ready <= '0;
            req_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        mem_valid <= 1'b1;
                        mem_wr_rd <= sel_wr;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        grant_id  <= pick;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        req_ready  <= gnt_oh[NUM_REQ-1:0];
                        last_grant <= grant_id;
                        if (!mem_wr_rd)
                            req_rdata <= mem_rdata;
                    end else if (tmo) begin
                        mem_valid  <= 1'b0;
                        req_ready  <= gnt_oh[NUM_REQ-1:0];
                        req_err    <= 1'b1;
                        last_grant <= grant_id;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_mem_arbiter;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int N  = 2;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_wr_rd = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*W-1:0]  req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic            req_err;
    logic [W-1:0]    req_rdata;
    logic            mem_valid;
    logic            mem_wr_rd;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata;
    logic            mem_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr_rd(req_wr_rd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_id(grant_id), .busy(busy)
    );

    // Simple memory behind the arbiter
    logic [W-1:0] tbmem [16];
    assign mem_rdata = tbmem[mem_addr];

    always @(posedge clk)
        if (mem_valid && mem_ready && mem_wr_rd)
            tbmem[mem_addr] <= mem_wdata;

    // Responder: assert mem_ready on the rdelay-th BUSY cycle (0-based), never if -1
    int rdelay = 0;
    int bc = 0;
    bit noise = 0;
    always @(negedge clk) begin
        if (mem_valid) begin
            mem_ready = (rdelay >= 0 && bc == rdelay);
            bc++;
        end else begin
            mem_ready = noise;
            bc = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner = granted requester (-1 none), waited = BUSY cycles elapsed
    int          owner = -1;
    int          last  = N - 1;
    int          waited = 0;
    int          rr;
    bit          done = 0;
    logic          exp_mv = 0, exp_wr = 0, exp_err = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [W-1:0]  exp_wd = '0, exp_rdata = '0;
    logic [N-1:0]  exp_rdy = '0;
    logic [1:0]    exp_gid = '0;

    always @(posedge clk) begin
        if (rst) begin
            owner = -1; last = N - 1; waited = 0; done = 0;
            exp_mv = 0; exp_wr = 0; exp_err = 0; exp_addr = '0;
            exp_wd = '0; exp_rdata = '0; exp_rdy = '0; exp_gid = '0;
        end else if (done) begin
            done = 0;
            exp_rdy = '0;
            exp_err = 0;
        end else if (owner < 0) begin
            for (int j = 1; j <= N; j++) begin
                rr = (last + j) % N;
                if (owner < 0 && req_valid[rr]) owner = rr;
            end
            if (owner >= 0) begin
                exp_mv   = 1;
                exp_wr   = req_wr_rd[owner];
                exp_addr = req_addr[owner*AW +: AW];
                exp_wd   = req_wdata[owner*W +: W];
                exp_gid  = 2'(owner);
                waited   = 0;
            end
        end else begin
            waited++;
            if (mem_ready || waited == TO) begin
                if (mem_ready && !exp_wr) exp_rdata = tbmem[exp_addr];
                exp_err = !mem_ready;
                exp_mv  = 0;
                exp_rdy = '0;
                exp_rdy[owner] = 1'b1;
                last  = owner;
                owner = -1;
                done  = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_valid", 32'(mem_valid), 32'(exp_mv));
            chk("busy", 32'(busy), 32'((owner >= 0) || done));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("req_err", 32'(req_err), 32'(exp_err));
            chk("grant_id", 32'(grant_id), 32'(exp_gid));
            chk("req_rdata", 32'(req_rdata), 32'(exp_rdata));
            if (exp_mv) begin
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
                chk("mem_wr_rd", 32'(mem_wr_rd), 32'(exp_wr));
            end
        end
    end

    task automatic wait_rdy(input int i, input int maxc, output int lat, output logic err);
        lat = 0;
        err = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (req_ready[i]) begin
                err = req_err;
                return;
            end
            if (lat >= maxc) begin
                chk("wait_ready", 0, 1);
                return;
            end
        end
    endtask

    task automatic xact(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input int dly,
                        output int lat, output logic err);
        rdelay = dly;
        req_wr_rd[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*W +: W] = d;
        req_valid[i] = 1'b1;
        wait_rdy(i, 40, lat, err);
        req_valid[i] = 1'b0;
    endtask

    int       lat, lat2, got, cyc, rises, last_rise, viol;
    logic     err;
    logic [1:0] order [4];
    logic [1:0] rr_exp [4];
    logic     prev_mv, prev_rdy;

    initial begin
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd0; rr_exp[3] = 2'd1;

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_req_rdata", 32'(req_rdata), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read, mem_ready delayed 2 cycles
        xact(0, 1'b1, 4'd3, 16'hA5A5, 2, lat, err);
        chk("wr_latency", 32'(lat), 4);
        chk("wr_err", 32'(err), 0);
        @(negedge clk);
        chk("wr_ready_one_cycle", 32'(req_ready), 0);
        xact(0, 1'b0, 4'd3, 16'h0000, 1, lat, err);
        chk("rd_err", 32'(err), 0);
        chk("rd_data", 32'(req_rdata), 32'h0000A5A5);

        // Contention from reset, with mem_ready noise outside BUSY
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        noise = 1;
        rdelay = 0;
        req_wr_rd = 2'b11;
        req_addr  = {4'd1, 4'd0};
        req_wdata = {16'h2222, 16'h1111};
        req_valid = 2'b11;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (|req_ready) begin
                order[got] = grant_id;
                got++;
            end
        end
        req_valid = '0;
        noise = 0;
        chk("rr_count", 32'(got), 4);
        for (int k = 0; k < 4; k++)
            if (k < got) chk("rr_order", 32'(order[k]), 32'(rr_exp[k]));

        // Timeout, with requester fields changed after the grant
        repeat (2) @(negedge clk);
        rdelay = -1;
        req_wr_rd[0] = 1'b1;
        req_addr[0 +: AW] = 4'd9;
        req_wdata[0 +: W] = 16'h1111;
        req_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        req_wdata[0 +: W] = 16'hFFFF;
        req_addr[0 +: AW] = 4'd2;
        wait_rdy(0, 40, lat2, err);
        req_valid[0] = 1'b0;
        chk("tmo_latency", 32'(lat2 + 3), 16);
        chk("tmo_err", 32'(err), 1);
        @(negedge clk);
        chk("tmo_mv_low", 32'(mem_valid), 0);
        chk("tmo_ready_low", 32'(req_ready), 0);

        // Boundary: mem_ready on the 15th BUSY cycle
        xact(1, 1'b1, 4'd7, 16'h5A5A, 0, lat, err);
        @(negedge clk);
        xact(1, 1'b0, 4'd7, 16'h0000, 14, lat, err);
        chk("bnd_latency", 32'(lat), 16);
        chk("bnd_err", 32'(err), 0);
        chk("bnd_data", 32'(req_rdata), 32'h00005A5A);

        // Reset mid-BUSY
        @(negedge clk);
        rdelay = -1;
        req_wr_rd[1] = 1'b0;
        req_addr[AW +: AW] = 4'd3;
        req_valid[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(mem_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_mv", 32'(mem_valid), 0);
        chk("rst_mid_ready", 32'(req_ready), 0);
        rdelay = 0;
        req_wr_rd[0] = 1'b1;
        req_addr[0 +: AW] = 4'd4;
        req_wdata[0 +: W] = 16'h0BAD;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_next_grant", 32'(grant_id), 0);
        chk("rst_next_mv", 32'(mem_valid), 1);
        wait_rdy(0, 40, lat, err);
        req_valid[0] = 1'b0;
        wait_rdy(1, 40, lat, err);
        req_valid[1] = 1'b0;
        chk("rst_req1_data", 32'(req_rdata), 32'h0000A5A5);

        // Back-to-back with req1 held valid
        @(negedge clk);
        rdelay = 0;
        req_wr_rd[1] = 1'b0;
        req_addr[AW +: AW] = 4'd3;
        req_valid[1] = 1'b1;
        prev_mv = 0;
        prev_rdy = 0;
        rises = 0;
        last_rise = 0;
        viol = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (mem_valid && !prev_mv) begin
                if (rises > 0) chk("b2b_gap", 32'(c - last_rise), 3);
                last_rise = c;
                rises++;
            end
            if (req_ready[1] && prev_rdy) viol++;
            prev_mv = mem_valid;
            prev_rdy = req_ready[1];
        end
        req_valid[1] = 1'b0;
        chk("b2b_rises", 32'(rises), 5);
        chk("b2b_ready_runs", 32'(viol), 0);
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
